uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding,
// byte width and the default header base byte.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HEADER_BASE_DEF = 8'hA0;

  // Plain vector encoding keeps the state constants usable by older tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HEADER = 2'd1;
  localparam state_t ST_XFER   = 2'd2;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from last_i+1,
// wrapping modulo NUM_REQ. Purely combinational.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_i) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding per-requester byte packets into a single
// TX FIFO. A grant lasts until the packet's last byte or the burst cap.
// Optional macro UART_TX_ARB_HEADER_EN prefixes every grant with a header
// byte HEADER_BASE | grant index.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                MAX_BURST   = 16,
  parameter logic [BYTE_W-1:0] HEADER_BASE = HEADER_BASE_DEF,
  localparam int               GW          = $clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_wren,
  input  logic                      tx_fifo_full,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q,  last_d;
  logic [7:0]        cnt_q,   cnt_d;

  logic              found;
  logic [GW-1:0]     pick;
  logic              own_valid, own_last, accept, cap_hit;
  logic [BYTE_W-1:0] own_data;
  logic [8:0]        cnt_inc;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IW(GW)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .found_o (found),
    .idx_o   (pick)
  );

  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[grant_q*BYTE_W +: BYTE_W];
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  // Cap compares the post-increment count; MAX_BURST=0 disables it.
  assign cap_hit   = (MAX_BURST != 0) && (cnt_inc == 9'(MAX_BURST));
  assign accept    = (state_q == ST_XFER) && tx_wren;

  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;

  // FIFO write side and requester handshake, all same-cycle combinational.
  always_comb begin
    tx_wren   = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state_q)
      ST_XFER: begin
        tx_wren            = own_valid & ~tx_fifo_full;
        tx_data            = own_data;
        req_ready[grant_q] = tx_wren;
      end
`ifdef UART_TX_ARB_HEADER_EN
      ST_HEADER: begin
        tx_wren = ~tx_fifo_full;
        tx_data = HEADER_BASE | BYTE_W'(grant_q);
      end
`endif
      default: ;
    endcase
  end

  // Grant sequencing: pick in IDLE, hold through the packet, release on
  // last byte or burst cap. Owner dropping valid just stalls the grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
`ifdef UART_TX_ARB_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      ST_HEADER: begin
        if (!tx_fifo_full) state_d = ST_XFER;
      end
`endif
      ST_XFER: begin
        if (accept) begin
          if (own_last || cap_hit) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
            cnt_d   = '0;
          end else begin
            // Only reachable past 255 when the cap is disabled.
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_q resets to the top index so requester 0 wins first.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level reference model
// predicts every FIFO write; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int GW = 2;
  localparam logic [7:0] HB = 8'hA0;
`ifdef UART_TX_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           sys_clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [N*8-1:0] req_data = '0;
  logic [7:0]     tx_data;
  logic           tx_wren, busy;
  logic           tx_fifo_full = 1'b0;
  logic [GW-1:0]  grant_id;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .HEADER_BASE(HB)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_wren      (tx_wren),
    .tx_fifo_full (tx_fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  typedef struct packed { logic [7:0] d; logic [GW-1:0] g; } wr_t;

  int         checks = 0, errors = 0;
  wr_t        wq[$];
  logic [8:0] src[N][$];            // {last, data} per pending byte
  int         own = -1, lastg = N - 1, cnt = 0;
  bit         hdr = 1'b0;
  bit         mon_en = 1'b0;
  bit         exp_wren, exp_busy;
  logic [N-1:0] exp_ready;
  int         exp_gid;
  int         vprob = 100, full_pct = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = (base < 0) ? 8'($urandom_range(255)) : 8'(base + j * 8'h11);
      src[r].push_back({(j == len - 1), b});
    end
  endtask

  // One clock of stimulus: drive inputs, predict outputs, advance the model.
  task automatic step(input int fm);
    logic f;
    logic [8:0] head;
    wr_t w;
    f = (fm < 0) ? ($urandom_range(99) < full_pct) : fm[0];
    tx_fifo_full = f;
    for (int i = 0; i < N; i++) begin
      head = (src[i].size() > 0) ? src[i][0] : 9'h0;
      req_valid[i] = (src[i].size() > 0) && ($urandom_range(99) < vprob);
      req_data[i*8 +: 8] = head[7:0];
      req_last[i] = head[8];
    end
    exp_busy  = (own >= 0);
    exp_gid   = own;
    exp_ready = '0;
    exp_wren  = 1'b0;
    if (own >= 0 && hdr) begin
      if (!f) begin
        exp_wren = 1'b1;
        w.d = HB | own[7:0]; w.g = own[GW-1:0];
        wq.push_back(w);
      end
    end else if (own >= 0 && req_valid[own] && !f) begin
      exp_wren = 1'b1;
      exp_ready[own] = 1'b1;
      w.d = req_data[own*8 +: 8]; w.g = own[GW-1:0];
      wq.push_back(w);
    end
    @(posedge sys_clk);
    if (own < 0) begin
      for (int k = 1; k <= N; k++)
        if (own < 0 && req_valid[(lastg + k) % N]) own = (lastg + k) % N;
      hdr = HDR_EN;
    end else if (hdr) begin
      if (!f) hdr = 1'b0;
    end else if (exp_ready[own]) begin
      cnt++;
      head = src[own][0];
      src[own].delete(0);
      if (head[8] || (MB != 0 && cnt == MB)) begin
        lastg = own; own = -1; cnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    req_valid = '0;
    tx_fifo_full = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_busy",  busy, 0);
    chk("rst_wren",  tx_wren, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid",   grant_id, 0);
    reset = 1'b0;
    own = -1; lastg = N - 1; cnt = 0; hdr = 1'b0;
    wq.delete();
    for (int i = 0; i < N; i++) src[i].delete();
    mon_en = 1'b1;
  endtask

  // Monitor: per-cycle status compare plus scoreboard pop on each write.
  always @(negedge sys_clk) begin
    wr_t e;
    if (mon_en) begin
      chk("wren",  tx_wren, exp_wren);
      chk("ready", req_ready, exp_ready);
      chk("busy",  busy, exp_busy);
      if (exp_busy) chk("grant_id", grant_id, exp_gid);
      if (tx_wren && tx_fifo_full) chk("wren_when_full", 1, 0);
      if (tx_wren) begin
        if (wq.size() == 0) chk("unexpected_write", tx_data, 32'hFFFF_FFFF);
        else begin
          e = wq.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("wr_owner", grant_id, e.g);
        end
      end
    end
  end

  initial begin
    int pending;
    do_reset();

    // single 3-byte packet from requester 0
    src[0].push_back({1'b0, 8'h11});
    src[0].push_back({1'b0, 8'h22});
    src[0].push_back({1'b1, 8'h33});
    repeat (8) step(0);

    // contention: all requesters with 1-byte packets, requester 0 twice
    do_reset();
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'h40 + i);
    push_pkt(0, 1, 8'h50);
    repeat (16) step(0);

    // backpressure for 5 cycles mid-packet
    push_pkt(1, 6, 8'h01);
    repeat (3) step(0);
    repeat (5) step(1);
    repeat (10) step(0);

    // burst cap with a competitor pending
    push_pkt(1, 10, 8'h02);
    push_pkt(2, 3, 8'h80);
    repeat (30) step(0);

    // reset after 2 of 5 bytes, then requester 0 must win
    push_pkt(2, 5, 8'h03);
    repeat (3) step(0);
    do_reset();
    push_pkt(3, 1, 8'hC3);
    push_pkt(0, 1, 8'hC0);
    repeat (8) step(0);

    // randomized traffic with valid gaps and FIFO backpressure
    vprob = 80; full_pct = 25;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (src[i].size() == 0 && $urandom_range(3) == 0)
          push_pkt(i, $urandom_range(1, 9), -1);
      step(-1);
    end

    // drain with a bounded cycle budget
    vprob = 100;
    for (int t = 0; t < 2000; t++) begin
      pending = (own >= 0) ? 1 : 0;
      for (int i = 0; i < N; i++) pending += src[i].size();
      if (pending == 0) break;
      step(0);
    end
    pending = (own >= 0) ? 1 : 0;
    for (int i = 0; i < N; i++) pending += src[i].size();
    chk("drain_pending", pending, 0);
    chk("scoreboard_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
